// File: rtl/rv32_pipe_core.sv
// Five-stage RV32I-subset pipeline (F/D/E/M/W) with E-stage forwarding, load-use
// stall, taken-transfer flush and a write-through register file.
module rv32_pipe_core #(
    parameter int          DATA_WIDTH      = 32,
    parameter int          IMEM_ADDR_WIDTH = 8,
    parameter int          DMEM_ADDR_WIDTH = 8,
    parameter logic [31:0] RESET_PC        = 32'h0,
    parameter int          CNT_WIDTH       = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [DATA_WIDTH-1:0]      a0,
    output logic [31:0]                instruction,
    output logic [IMEM_ADDR_WIDTH-1:0] pc_addr,
    output logic                       stall,
    output logic                       flush,
    output logic [CNT_WIDTH-1:0]       retired
);
    localparam int W = DATA_WIDTH;
    localparam logic [W-1:0] FOUR = W'(4);
    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2,
                           ALU_OR = 3'd3, ALU_SLT = 3'd4, ALU_PASSB = 3'd5;
    localparam logic [1:0] RES_ALU = 2'd0, RES_MEM = 2'd1, RES_PC4 = 2'd2;
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011,
                           OP_SW = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       branch_ne;
        logic       jump;
        logic       jalr;
        logic       alu_imm;
        logic [1:0] result_src;
        logic [2:0] alu_op;
    } ctrl_t;

    logic [31:0]  imem [2**(IMEM_ADDR_WIDTH-2)];
    logic [W-1:0] dmem [2**(DMEM_ADDR_WIDTH-2)];
    logic [W-1:0] regs [32];

    logic [W-1:0] pc_f, pc_d, pc_e, pc4_e, pc4_m, pc4_w;
    logic [31:0]  instr_f, instr_d, imm32_d;
    logic [6:0]   opcode_d;
    logic [2:0]   funct3_d;
    logic [4:0]   rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    ctrl_t        ctrl_d, ctrl_e;
    logic         use1_d, use2_d, hazard, taken_e, kill_e;
    logic [W-1:0] imm_d, rd1_d, rd2_d, imm_e, rd1_e, rd2_e;
    logic [W-1:0] fwd_m, src_a, fwd_b, src_b, alu_e, target_e;
    logic         reg_write_m, mem_write_m, valid_m, reg_write_w, valid_w;
    logic [1:0]   result_src_m, result_src_w;
    logic [W-1:0] alu_m, wdata_m, rdata_m, alu_w, rdata_w, result_w;

    assign pc_addr     = pc_f[IMEM_ADDR_WIDTH-1:0];
    assign instr_f     = imem[pc_addr[IMEM_ADDR_WIDTH-1:2]];
    assign instruction = instr_f;
    assign a0          = regs[10];

    assign opcode_d = instr_d[6:0];
    assign rd_d     = instr_d[11:7];
    assign funct3_d = instr_d[14:12];
    assign rs1_d    = instr_d[19:15];
    assign rs2_d    = instr_d[24:20];

    always_comb begin
        ctrl_d  = '0;
        use1_d  = 1'b0;
        use2_d  = 1'b0;
        imm32_d = {{20{instr_d[31]}}, instr_d[31:20]};
        case (opcode_d)
            OP_R: begin
                ctrl_d.valid = 1'b1; ctrl_d.reg_write = 1'b1; use1_d = 1'b1; use2_d = 1'b1;
                case (funct3_d)
                    3'b000:  ctrl_d.alu_op = instr_d[30] ? ALU_SUB : ALU_ADD;
                    3'b010:  ctrl_d.alu_op = ALU_SLT;
                    3'b110:  ctrl_d.alu_op = ALU_OR;
                    3'b111:  ctrl_d.alu_op = ALU_AND;
                    default: ctrl_d = '0;
                endcase
            end
            OP_I: begin
                ctrl_d.valid = 1'b1; ctrl_d.reg_write = 1'b1; ctrl_d.alu_imm = 1'b1; use1_d = 1'b1;
                case (funct3_d)
                    3'b000:  ctrl_d.alu_op = ALU_ADD;
                    3'b010:  ctrl_d.alu_op = ALU_SLT;
                    3'b110:  ctrl_d.alu_op = ALU_OR;
                    3'b111:  ctrl_d.alu_op = ALU_AND;
                    default: ctrl_d = '0;
                endcase
            end
            OP_LW: begin
                ctrl_d.valid = 1'b1; ctrl_d.reg_write = 1'b1; ctrl_d.alu_imm = 1'b1;
                ctrl_d.result_src = RES_MEM; use1_d = 1'b1;
            end
            OP_SW: begin
                ctrl_d.valid = 1'b1; ctrl_d.mem_write = 1'b1; ctrl_d.alu_imm = 1'b1;
                use1_d = 1'b1; use2_d = 1'b1;
                imm32_d = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
            end
            OP_BR: begin
                ctrl_d.valid = 1'b1; ctrl_d.branch = 1'b1; ctrl_d.branch_ne = funct3_d[0];
                use1_d = 1'b1; use2_d = 1'b1;
                imm32_d = {{20{instr_d[31]}}, instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0};
                if (funct3_d[2:1] != 2'b00) ctrl_d = '0;
            end
            OP_JAL: begin
                ctrl_d.valid = 1'b1; ctrl_d.reg_write = 1'b1; ctrl_d.jump = 1'b1;
                ctrl_d.result_src = RES_PC4;
                imm32_d = {{12{instr_d[31]}}, instr_d[19:12], instr_d[20], instr_d[30:21], 1'b0};
            end
            OP_JALR: begin
                ctrl_d.valid = 1'b1; ctrl_d.reg_write = 1'b1; ctrl_d.jump = 1'b1;
                ctrl_d.jalr = 1'b1; ctrl_d.result_src = RES_PC4; use1_d = 1'b1;
            end
            OP_LUI: begin
                ctrl_d.valid = 1'b1; ctrl_d.reg_write = 1'b1; ctrl_d.alu_imm = 1'b1;
                ctrl_d.alu_op = ALU_PASSB; imm32_d = {instr_d[31:12], 12'b0};
            end
            default: ;
        endcase
    end

    assign imm_d = W'($signed(imm32_d));
    // Write-through: a read of the register W is writing this cycle sees ResultW.
    assign rd1_d = (reg_write_w && rd_w != 5'd0 && rd_w == rs1_d) ? result_w : regs[rs1_d];
    assign rd2_d = (reg_write_w && rd_w != 5'd0 && rd_w == rs2_d) ? result_w : regs[rs2_d];

    assign hazard = ctrl_e.valid && ctrl_e.result_src == RES_MEM && rd_e != 5'd0 && ctrl_d.valid &&
                    ((use1_d && rs1_d == rd_e) || (use2_d && rs2_d == rd_e));
    assign flush  = taken_e;
    assign stall  = hazard && !taken_e;
    assign kill_e = taken_e || hazard || !ctrl_d.valid;

    assign fwd_m = (result_src_m == RES_PC4) ? pc4_m : alu_m;

    always_comb begin
        src_a = rd1_e;
        if (reg_write_m && rd_m != 5'd0 && rd_m == rs1_e)      src_a = fwd_m;
        else if (reg_write_w && rd_w != 5'd0 && rd_w == rs1_e) src_a = result_w;
        fwd_b = rd2_e;
        if (reg_write_m && rd_m != 5'd0 && rd_m == rs2_e)      fwd_b = fwd_m;
        else if (reg_write_w && rd_w != 5'd0 && rd_w == rs2_e) fwd_b = result_w;
    end

    assign src_b = ctrl_e.alu_imm ? imm_e : fwd_b;

    always_comb begin
        case (ctrl_e.alu_op)
            ALU_SUB:   alu_e = src_a - src_b;
            ALU_AND:   alu_e = src_a & src_b;
            ALU_OR:    alu_e = src_a | src_b;
            ALU_SLT:   alu_e = {{(W-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            ALU_PASSB: alu_e = src_b;
            default:   alu_e = src_a + src_b;
        endcase
    end

    assign taken_e  = ctrl_e.valid &&
                      (ctrl_e.jump || (ctrl_e.branch && ((src_a == fwd_b) ^ ctrl_e.branch_ne)));
    assign target_e = ctrl_e.jalr ? ((src_a + imm_e) & {{(W-1){1'b1}}, 1'b0}) : (pc_e + imm_e);
    assign pc4_e    = pc_e + FOUR;

    assign rdata_m = dmem[alu_m[DMEM_ADDR_WIDTH-1:2]];

    always_comb begin
        case (result_src_w)
            RES_MEM: result_w = rdata_w;
            RES_PC4: result_w = pc4_w;
            default: result_w = alu_w;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_f <= W'(RESET_PC);
            instr_d <= '0; pc_d <= '0;
            ctrl_e <= '0; rd1_e <= '0; rd2_e <= '0; imm_e <= '0; pc_e <= '0;
            rs1_e <= '0; rs2_e <= '0; rd_e <= '0;
            valid_m <= 1'b0; reg_write_m <= 1'b0; mem_write_m <= 1'b0; result_src_m <= RES_ALU;
            alu_m <= '0; wdata_m <= '0; pc4_m <= '0; rd_m <= '0;
            valid_w <= 1'b0; reg_write_w <= 1'b0; result_src_w <= RES_ALU;
            alu_w <= '0; rdata_w <= '0; pc4_w <= '0; rd_w <= '0;
            retired <= '0;
        end else begin
            if (taken_e) begin
                pc_f <= target_e; instr_d <= '0; pc_d <= '0;
            end else if (!hazard) begin
                pc_f <= pc_f + FOUR; instr_d <= instr_f; pc_d <= pc_f;
            end
            ctrl_e <= kill_e ? '0 : ctrl_d;
            rd_e   <= kill_e ? 5'd0 : rd_d;
            rd1_e <= rd1_d; rd2_e <= rd2_d; imm_e <= imm_d; pc_e <= pc_d;
            rs1_e <= rs1_d; rs2_e <= rs2_d;
            valid_m <= ctrl_e.valid; reg_write_m <= ctrl_e.reg_write;
            mem_write_m <= ctrl_e.mem_write; result_src_m <= ctrl_e.result_src;
            alu_m <= alu_e; wdata_m <= fwd_b; pc4_m <= pc4_e; rd_m <= rd_e;
            valid_w <= valid_m; reg_write_w <= reg_write_m; result_src_w <= result_src_m;
            alu_w <= alu_m; rdata_w <= rdata_m; pc4_w <= pc4_m; rd_w <= rd_m;
            if (valid_w) retired <= retired + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (reg_write_w && rd_w != 5'd0) begin
            regs[rd_w] <= result_w;
        end
    end

    // The data RAM is not reset; the rst guard blocks writes on edges taken under reset.
    always_ff @(posedge clk) begin
        if (!rst && mem_write_m) dmem[alu_m[DMEM_ADDR_WIDTH-1:2]] <= wdata_m;
    end
endmodule

// File: doc/rv32_pipe_core.md
Name: rv32_pipe_core

Overview:
- Next-generation 5-stage (F/D/E/M/W) RV32I-subset pipelined core.
- Adds hazard handling that the current pipelined top lacks:
  - E-stage operand forwarding from M and W.
  - Load-use stall.
  - Control-hazard flush on taken branch or jump.
  - A register file with an internal write-through bypass.
- Memory widths, reset PC and retire-counter width are parametrised. The block is the top level for simulation and bring-up.

Parameters:
DATA_WIDTH, 32, datapath and register width
IMEM_ADDR_WIDTH, 8, byte-address bits decoded by the instruction ROM
DMEM_ADDR_WIDTH, 8, byte-address bits decoded by the data RAM
RESET_PC, 32'h0, PC value loaded on reset
CNT_WIDTH, 32, width of the retired-instruction counter

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-high reset
a0  out  DATA_WIDTH  live value of register x10
instruction  out  32  instruction currently in F (instrF)
pc_addr  out  IMEM_ADDR_WIDTH  PCF[IMEM_ADDR_WIDTH-1:0]
stall  out  1  high in any cycle F/D are held for load-use
flush  out  1  high in any cycle D/E are squashed by a taken control transfer
retired  out  CNT_WIDTH  count of non-bubble instructions completing W

Behaviour:
- Reset (one clock; reset asynchronous and active-high):
  - PCF = RESET_PC.
  - All pipeline registers are cleared to a bubble: every control bit 0, RdX = 0.
  - x1..x31 = 0, so a0 = 0.
  - retired = 0; stall = 0, flush = 0.
  - Effect is immediate, without waiting for clk.
  - Reset asserted mid-operation discards all in-flight instructions. No memory write occurs on the edge where rst is high.
- Supported instructions:
  - R-type: add, sub, and, or, slt.
  - I-type: addi, andi, ori, slti.
  - lw, sw, beq, bne, jal, jalr, lui.
  - Any other opcode decodes as a bubble and does not count as retired.
- Memories:
  - Instruction ROM is combinational read.
  - Data RAM is combinational read in M and synchronous write on the clk edge with MemWriteM.
  - Addresses are truncated to the *_ADDR_WIDTH LSBs and wrap modulo 2^width.
- Register file:
  - Writes on the clk edge in W.
  - A D-stage read of the register being written in W that cycle returns ResultW (write-through bypass).
  - x0 always reads 0 and is never written.
- Forwarding (E-stage operands Rs1E/Rs2E), in priority order:
  - If RegWriteM, RdM != 0 and RdM == RsE: take ALUResultM, or PCPlus4M for jal/jalr in M.
  - Else if RegWriteW, RdW != 0 and RdW == RsE: take ResultW.
  - Otherwise take the register-file value.
  - The store data (RD2 path) uses the same forwarding.
- Load-use stall:
  - Condition: E holds lw, RdE != 0, and RdE equals Rs1D or Rs2D of the instruction in D (only for fields that instruction actually uses).
  - Action: hold PCF and the F/D register, insert a bubble into E, assert stall for exactly 1 cycle.
- Control transfers (resolved in E):
  - beq/bne taken: target = PCE + ImmExtE.
  - jal: target = PCE + ImmExtE.
  - jalr: target = (RD1E_fwd + ImmExtE) & ~1.
  - When taken: PCF <= target on the next edge, D and E are replaced by bubbles, flush = 1 for 1 cycle.
  - Penalty is 2 cycles. Not-taken costs 0.
- Simultaneous stall and flush: flush wins. PC takes the target, D and E become bubbles, stall is forced to 0.
- Retire counter: increments by 1 on each edge where W holds a non-bubble instruction. Wraps modulo 2^CNT_WIDTH.
- Latency: an instruction issued at fetch cycle n writes back at the edge ending cycle n+4, absent stalls and flushes.

Test Plan:
1. Run for 10 cycles, then assert rst between edges → pc_addr = 0, a0 = 0, retired = 0 immediately. After release, the first instruction at RESET_PC retires 5 edges later.
2. Run `addi a0,x0,5; addi a0,a0,3; add a0,a0,a0` → a0 = 16, retired = 3, stall never asserted (M and W forwarding both exercised).
3. Run `addi t1,x0,0x2A; sw t1,4(x0); lw t0,4(x0); addi a0,t0,1` → stall high exactly 1 cycle, a0 = 0x2B, retired = 4.
4. Run `beq x0,x0,+12; addi a0,x0,1; addi a0,x0,2; addi a0,a0,7` → flush high 1 cycle, a0 = 7, retired = 2.
5. Run `jal ra,+8` at PC 0x10, then `jalr x0,0(ra)` at the target → ra = 0x14, then PC returns to 0x14. Each jump asserts flush once; link value forwarded correctly.
6. With CNT_WIDTH = 4, retire 17 `addi x0,x0,0` instructions → retired = 1. Separately, an sw to address 0x104 with DMEM_ADDR_WIDTH = 8 aliases to 0x04 on a subsequent lw.
